load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle byte-addressed load/store front end sitting directly upstream of data_memory.
//  Accepts core requests (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready handshake and drives
//  data_memory's word-indexed port: word index out, write data out, write enable out, read data in.
//  Does byte-lane extraction and sign/zero extension for loads.
//  Implements SB/SH as read-modify-write, because data_memory has no byte enables.
// PARAMETERS
//  XLEN       32    data width, from riscv_pkg
//  DMEM_SIZE  1024  memory depth in words, from riscv_pkg; AW = $clog2(DMEM_SIZE)
// PORTS
//  clk                input   1      clock, all state on posedge
//  rst                input   1      asynchronous, active-high reset
//  req_valid          input   1      core request valid
//  req_ready          output  1      LSU can accept a request (high only in IDLE)
//  req_we             input   1      1 = store, 0 = load
//  req_size           input   2      mem_size_e: MEM_B / MEM_H / MEM_W
//  req_unsigned       input   1      load zero-extends (LBU/LHU); ignored for stores and words
//  req_addr           input   XLEN   byte address
//  req_wdata          input   XLEN   store data, right-aligned
//  rsp_valid          output  1      one-cycle response pulse
//  rsp_rdata          output  XLEN   extended load data; 0 for stores and on error
//  rsp_err            output  1      misaligned access (valid with rsp_valid)
//  data_addr          output  AW     word index = req_addr[AW+1:2], latched at acceptance
//  data_write_data    output  XLEN   word to write
//  data_write_enable  output  1      one-cycle write strobe
//  data_read_data     input   XLEN   combinational read of word at data_addr
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; data_addr=0;
//   data_write_data=0; data_write_enable=0. All request fields and the data register clear.
//  Handshake: a request is accepted on the posedge where req_valid & req_ready. The LSU latches
//   addr, size, we, unsigned and wdata. Inputs are ignored while busy; one request in flight max.
//  FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
//   - IDLE -> RESP (err): misaligned, i.e. H with addr[0]!=0, or W with addr[1:0]!=0
//     (see CONFIGURATION).
//   - IDLE -> LOAD on a load; IDLE -> WRITE on SW; IDLE -> MERGE on SB/SH.
//   - LOAD: register lane-extracted, extended data_read_data -> RESP.
//   - MERGE: register data_read_data with new lanes replaced by req_wdata low bits -> WRITE.
//   - WRITE: data_write_enable=1 for exactly this cycle -> RESP.
//   - RESP: rsp_valid=1 for one cycle -> IDLE.
//  Latency, acceptance edge to rsp_valid high: load 2 cycles, SW 2 cycles, SB/SH 3 cycles,
//   error 1 cycle. Next request is acceptable on the cycle after RESP.
//  Lane rules (little-endian): byte k = word[8k+7:8k], k = addr[1:0]. Half uses addr[1] (bits 31:16
//   or 15:0). Sign-extend from bit 7 or 15 unless req_unsigned. Word loads pass through unchanged.
//  Address bits above AW+1 are ignored: the word index wraps modulo DMEM_SIZE.
//  Reset mid-operation: any state returns to IDLE immediately. A reset asserted during MERGE
//   or WRITE causes no write at all; partial writes are impossible.
//  data_write_enable is asserted only in WRITE; data_write_data is stable for that whole cycle.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: misaligned requests cause no memory access and no write.
//   They go to RESP with rsp_err=1 and rsp_rdata=0.
//  LSU_MISALIGN_TRAP_EN undefined: misaligned low address bits are forced to 0 (H: addr[0],
//   W: addr[1:0]). The access then proceeds normally; rsp_err is tied to 0.
// STRUCTURE
//  riscv_pkg additions: typedef enum logic [1:0] {MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10}
//   mem_size_e; typedef enum lsu_state_e {LSU_IDLE, LSU_LOAD, LSU_MERGE, LSU_WRITE, LSU_RESP}.
//  Sub-module lsu_byte_lane (combinational): extract+extend for loads, merge for stores.
//   Shared by LOAD and MERGE.
// TESTING
//  1. SW addr 0x10 data 0xDEADBEEF -> data_write_enable one cycle, data_addr=4; LW 0x10 -> 0xDEADBEEF.
//  2. LB 0x11 -> 0xFFFFFFBE; LBU 0x11 -> 0x000000BE; LHU 0x12 -> 0x0000DEAD; LH 0x12 -> 0xFFFFDEAD.
//  3. SB 0x12 data 0x00000055 (RMW, 3-cycle latency) -> LW 0x10 returns 0xDE55BEEF.
//  4. With LSU_MISALIGN_TRAP_EN: SH 0x11 -> rsp_err=1 after 1 cycle, no write, LW 0x10 unchanged.
//     Without it: SH 0x11 writes lanes 1:0.
//  5. req_valid held high during a busy SB: req_ready=0 and no second accept until after RESP.
//     Then back-to-back LW 0x0 / LW 0xFFC -> data_addr 0 then 1023.
//  6. Assert rst during MERGE of SB 0x20 -> no data_write_enable pulse, outputs at reset values,
//     word at 0x20 unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and types for the load/store path (XLEN, data memory depth, sizes, LSU states).
// Revision: 1.0
`default_nettype none

package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int DMEM_SIZE = 1024;
  localparam int AW        = $clog2(DMEM_SIZE);

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_LOAD  = 3'd1,
    LSU_MERGE = 3'd2,
    LSU_WRITE = 3'd3,
    LSU_RESP  = 3'd4
  } lsu_state_e;

  // Anything that is not a byte or half is treated as a word access.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Revision: 1.0
`default_nettype none

module lsu_byte_lane
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  mem_size_e       size,
  input  logic [1:0]      offset,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  always_comb begin
    shifted   = word >> {offset, 3'b000};
    byte_sel  = shifted[7:0];
    half_sel  = offset[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = word;
    case (size)
      MEM_B: begin
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      MEM_H: begin
        load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-only data memory (RMW for SB/SH).
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests return rsp_err instead of being force-aligned.
`default_nettype none

module load_store_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [AW-1:0]   data_addr,
  output logic [XLEN-1:0] data_write_data,
  output logic            data_write_enable,
  input  logic [XLEN-1:0] data_read_data
);

  lsu_state_e      state, state_next;
  mem_size_e       size_in, size_q;
  logic [1:0]      off_q, off_in;
  logic            we_q, uns_q, err_q, misal, trap, accept;
  logic [XLEN-1:0] load_q, write_q, lane_load, lane_merged;
  logic            unused_addr_bits;

  assign size_in          = mem_size_e'(req_size);
  assign misal            = is_misaligned(size_in, req_addr[1:0]);
  assign accept           = req_valid && (state == LSU_IDLE);
  assign unused_addr_bits = ^req_addr[XLEN-1:AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap    = misal;
  assign off_in  = req_addr[1:0];
  assign rsp_err = (state == LSU_RESP) && err_q;
`else
  assign trap    = 1'b0;
  // Misaligned halves/words are silently snapped down to their natural boundary.
  assign off_in  = (size_in == MEM_B) ? req_addr[1:0] :
                   (size_in == MEM_H) ? {req_addr[1], 1'b0} : 2'b00;
  assign rsp_err = 1'b0;
`endif

  lsu_byte_lane u_lane (
    .word        (data_read_data),
    .wdata       (write_q),
    .size        (size_q),
    .offset      (off_q),
    .is_unsigned (uns_q),
    .load_data   (lane_load),
    .merged      (lane_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: begin
        if (req_valid) begin
          if (trap)                 state_next = LSU_RESP;
          else if (!req_we)         state_next = LSU_LOAD;
          else if (size_in == MEM_B ||
                   size_in == MEM_H) state_next = LSU_MERGE;
          else                      state_next = LSU_WRITE;
        end
      end
      LSU_LOAD:  state_next = LSU_RESP;
      LSU_MERGE: state_next = LSU_WRITE;
      LSU_WRITE: state_next = LSU_RESP;
      LSU_RESP:  state_next = LSU_IDLE;
      default:   state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q    <= MEM_B;
      off_q     <= 2'b00;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      data_addr <= '0;
      load_q    <= '0;
      write_q   <= '0;
    end else if (accept) begin
      size_q    <= size_in;
      off_q     <= off_in;
      we_q      <= req_we;
      uns_q     <= req_unsigned;
      err_q     <= trap;
      data_addr <= req_addr[AW+1:2];
      load_q    <= '0;
      write_q   <= req_wdata;
    end else if (state == LSU_LOAD) begin
      load_q    <= lane_load;
    end else if (state == LSU_MERGE) begin
      write_q   <= lane_merged;
    end
  end

  assign req_ready         = (state == LSU_IDLE);
  assign rsp_valid         = (state == LSU_RESP);
  assign rsp_rdata         = (state == LSU_RESP && !we_q) ? load_q : '0;
  assign data_write_data   = write_q;
  assign data_write_enable = (state == LSU_WRITE);

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a word memory model and a reference byte-lane model.
`default_nettype none

module tb_load_store_unit;
  import riscv_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [1:0]      req_size = 2'b00;
  logic            req_unsigned = 1'b0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   data_addr;
  logic [XLEN-1:0] data_write_data;
  logic            data_write_enable;
  logic [XLEN-1:0] data_read_data;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .data_addr(data_addr),
    .data_write_data(data_write_data), .data_write_enable(data_write_enable),
    .data_read_data(data_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [DMEM_SIZE];
  logic [31:0] ref_mem [DMEM_SIZE];
  assign data_read_data = mem[data_addr];
  always @(posedge clk) if (data_write_enable) mem[data_addr] <= data_write_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    logic [9:0]  addr;
  } exp_t;
  exp_t sbq[$];

  int cyc = 0, n_checks = 0, n_fail = 0, n_writes = 0, n_accepts = 0;
  logic [9:0] last_waddr = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (req_valid && req_ready && !rst) n_accepts++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (data_write_enable) begin
      n_writes++;
      last_waddr = data_addr;
    end
    if (rsp_valid) begin
      if (sbq.size() == 0) check("spurious_rsp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("latency", cyc - e.acc + 1, e.lat);
        check("data_addr", {22'd0, data_addr}, {22'd0, e.addr});
      end
    end
  end

  // Reference result for one request; updates ref_mem for stores that reach memory.
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    logic [31:0] a, w, m;
    logic        mis;
    int          sh;
    a   = addr;
    mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.addr  = a[11:2];
    e.rdata = 32'd0;
    e.err   = 1'b0;
    e.acc   = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
`else
    if (mis) a[1:0] = (sz == 2'b01) ? {a[1], 1'b0} : 2'b00;
`endif
    w  = ref_mem[a[11:2]];
    sh = 8 * int'(a[1:0]);
    if (!we) begin
      e.lat = 2;
      case (sz)
        2'b00: begin
          m = (w >> sh) & 32'hFF;
          e.rdata = (!uns && m[7]) ? (m | 32'hFFFFFF00) : m;
        end
        2'b01: begin
          m = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
          e.rdata = (!uns && m[15]) ? (m | 32'hFFFF0000) : m;
        end
        default: e.rdata = w;
      endcase
    end else begin
      case (sz)
        2'b00: begin m = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh); e.lat = 3; end
        2'b01: begin
          sh = a[1] ? 16 : 0;
          m = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
          e.lat = 3;
        end
        default: begin m = wd; e.lat = 2; end
      endcase
      ref_mem[a[11:2]] = m;
    end
    return e;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sbq.size() != 0 && k < 20) begin @(negedge clk); k++; end
    if (sbq.size() != 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    wait_ready();
    e = model(we, sz, uns, addr, wd);
    e.acc = cyc + 1;
    sbq.push_back(e);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    int w0, a0;
    exp_t e;
    for (int i = 0; i < DMEM_SIZE; i++) begin
      mem[i]     = (i * 32'h01010101) ^ 32'hA5C3_0F96;
      ref_mem[i] = (i * 32'h01010101) ^ 32'hA5C3_0F96;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_daddr", {22'd0, data_addr}, 32'd0);
    check("rst_wdata", data_write_data, 32'd0);
    check("rst_we", {31'd0, data_write_enable}, 32'd0);
    rst = 1'b0;

    w0 = n_writes;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_writes", n_writes - w0, 32'd1);
    check("sw_waddr", {22'd0, last_waddr}, 32'd4);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("sb_result", mem[4], 32'hDE55BEEF);

    w0 = n_writes;
    do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h00001234);
`ifdef LSU_MISALIGN_TRAP_EN
    check("sh_mis_writes", n_writes - w0, 32'd0);
`else
    check("sh_mis_writes", n_writes - w0, 32'd1);
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    // Busy SB with req_valid held: exactly one acceptance.
    @(negedge clk);
    wait_ready();
    a0 = n_accepts; w0 = n_writes;
    e = model(1'b1, 2'b00, 1'b0, 32'h15, 32'h000000A7);
    e.acc = cyc + 1;
    sbq.push_back(e);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h000000A7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    wait_drain();
    check("busy_accepts", n_accepts - a0, 32'd1);
    check("busy_writes", n_writes - w0, 32'd1);

    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0);

    // Reset while in MERGE: the RMW is abandoned with no write.
    @(negedge clk);
    wait_ready();
    w0 = n_writes;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h000000FF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_ready", {31'd0, req_ready}, 32'd1);
    check("mrst_we", {31'd0, data_write_enable}, 32'd0);
    check("mrst_daddr", {22'd0, data_addr}, 32'd0);
    check("mrst_wdata", data_write_data, 32'd0);
    check("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_writes", n_writes - w0, 32'd0);
    check("mrst_mem", mem[8], ref_mem[8]);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      ra = 32'h40 + $urandom_range(0, 31) + ($urandom_range(0, 3) << 12);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             ra, $urandom);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
